// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, reset values and NOP encoding for the fetch stage
//
// Provides the fallback values of the shared defines (ISIZE, NOP_INST, RESET_PC) when no
// project-wide define file has set them, and exposes them as package localparams.
// Also holds the load-source selector used by the fetch output register.

`ifndef ISIZE
`define ISIZE 32
`endif
`ifndef NOP_INST
`define NOP_INST 0
`endif
`ifndef RESET_PC
`define RESET_PC 0
`endif

package fetch_stage_pkg;

   localparam int ISIZE_DEF = `ISIZE;

   // All-zero NOP: what decode sees while nothing valid has been fetched.
   localparam logic [ISIZE_DEF-1:0] NOP_INST     = ISIZE_DEF'(`NOP_INST);
   localparam logic [ISIZE_DEF-1:0] RESET_PC_DEF = ISIZE_DEF'(`RESET_PC);

   // Where the output register takes its next contents from.
   typedef enum logic [1:0] {
      LD_HOLD  = 2'd0,   // keep current contents (stalled or idle)
      LD_CLEAR = 2'd1,   // consumed by decode, nothing to replace it
      LD_MEM   = 2'd2,   // fresh response from instruction memory
      LD_SKID  = 2'd3    // response parked in the skid buffer
   } out_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory, redirect and decode-handshake bundle
//
// Signals:
//   imem_en, imem_addr        fetch -> memory read request
//   imem_rdata                memory -> fetch, valid the cycle after the request
//   redirect_vld, redirect_pc execute -> fetch taken branch/jump
//   out_valid, out_inst, out_pc fetch -> decode
//   out_ready                 decode -> fetch
// Modports: master = fetch stage side, slave = environment (memory/execute/decode) side.

interface fetch_stage_if
   import fetch_stage_pkg::*;
#(
   parameter int W = ISIZE_DEF
);

   logic         imem_en;
   logic [W-1:0] imem_addr;
   logic [W-1:0] imem_rdata;
   logic         redirect_vld;
   logic [W-1:0] redirect_pc;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_inst;
   logic [W-1:0] out_pc;

   modport master (
      output imem_en, imem_addr, out_valid, out_inst, out_pc,
      input  imem_rdata, redirect_vld, redirect_pc, out_ready
   );

   modport slave (
      input  imem_en, imem_addr, out_valid, out_inst, out_pc,
      output imem_rdata, redirect_vld, redirect_pc, out_ready
   );

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {inst, pc} skid buffer, built only with FETCH_SKID_EN
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 discard the held entry (redirect)
//   in_valid/in_ready     write side; accepts only when empty
//   in_inst, in_pc        entry to capture
//   out_valid/out_ready   read side; entry leaves on out_valid & out_ready
//   out_inst, out_pc      held entry
// Macro: FETCH_SKID_EN (module exists only when defined).

`ifdef FETCH_SKID_EN
module fetch_skid_buf
   import fetch_stage_pkg::*;
#(
   parameter int ISIZE = ISIZE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ISIZE-1:0] in_inst,
   input  logic [ISIZE-1:0] in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ISIZE-1:0] out_inst,
   output logic [ISIZE-1:0] out_pc
);

   logic             vld_q;
   logic [ISIZE-1:0] inst_q;
   logic [ISIZE-1:0] pc_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         vld_q <= 1'b0;
      end else if (!vld_q) begin
         vld_q <= in_valid;
      end else if (out_ready) begin
         vld_q <= 1'b0;
      end

      // Payload needs no reset: it is only observed while vld_q is set.
      if (!vld_q && in_valid) begin
         inst_q <= in_inst;
         pc_q   <= in_pc;
      end
   end

   assign in_ready  = ~vld_q;
   assign out_valid = vld_q;
   assign out_inst  = inst_q;
   assign out_pc    = pc_q;

endmodule
`endif

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem request tracking and decode output register
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous reset, active-high; overrides every other input
//   bus        fetch_stage_if.master: imem_en/imem_addr/imem_rdata, redirect_vld/redirect_pc,
//              out_valid/out_ready/out_inst/out_pc
// Parameters: ISIZE (width), PC_STEP (increment per fetch), RESET_PC (PC after reset).
// Macro: FETCH_SKID_EN - when defined, a response arriving under back-pressure is parked in
//   a one-entry skid buffer; when undefined it is dropped and the PC rewinds to replay it.

module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int               ISIZE    = ISIZE_DEF,
   parameter int               PC_STEP  = 1,
   parameter logic [ISIZE-1:0] RESET_PC = ISIZE'(RESET_PC_DEF)
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   localparam logic [ISIZE-1:0] STEP = ISIZE'(PC_STEP);
   localparam logic [ISIZE-1:0] NOP  = ISIZE'(NOP_INST);

   logic [ISIZE-1:0] pc_q;
   logic             req_vld_q;
   logic [ISIZE-1:0] req_pc_q;
   logic             out_valid_q;
   logic [ISIZE-1:0] out_inst_q;
   logic [ISIZE-1:0] out_pc_q;

   logic             stall;
   logic             issue;
   logic             skid_vld;
   logic [ISIZE-1:0] skid_inst;
   logic [ISIZE-1:0] skid_pc;
   out_sel_e         out_sel;

   assign stall = out_valid_q & ~bus.out_ready;
   // A redirect cycle never issues: the old pc_q is wrong-path and the target is not
   // loaded until the edge.
   assign issue = ~stall & ~skid_vld & ~bus.redirect_vld & ~rst;

   assign bus.imem_en   = issue;
   assign bus.imem_addr = pc_q;

`ifdef FETCH_SKID_EN
   logic skid_push;
   logic skid_in_ready;

   // Only a response that cannot enter the stalled output register is parked.
   assign skid_push = req_vld_q & stall & skid_in_ready;

   fetch_skid_buf #(
      .ISIZE(ISIZE)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.redirect_vld),
      .in_valid (skid_push),
      .in_ready (skid_in_ready),
      .in_inst  (bus.imem_rdata),
      .in_pc    (req_pc_q),
      .out_valid(skid_vld),
      .out_ready(bus.out_ready),
      .out_inst (skid_inst),
      .out_pc   (skid_pc)
   );
`else
   assign skid_vld  = 1'b0;
   assign skid_inst = '0;
   assign skid_pc   = '0;
`endif

   // While the skid holds an entry no request is outstanding, so the skid and a memory
   // response never compete for the output register.
   always_comb begin
      out_sel = LD_HOLD;
      if (skid_vld && bus.out_ready) begin
         out_sel = LD_SKID;
      end else if (req_vld_q && !stall) begin
         out_sel = LD_MEM;
      end else if (bus.out_ready) begin
         out_sel = LD_CLEAR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         req_vld_q   <= 1'b0;
         req_pc_q    <= RESET_PC;
         out_valid_q <= 1'b0;
         out_inst_q  <= NOP;
         out_pc_q    <= '0;
      end else if (bus.redirect_vld) begin
         // Squash everything younger than the branch, including a stalled output.
         pc_q        <= bus.redirect_pc;
         req_vld_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         req_vld_q <= issue;
         if (issue) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + STEP;
         end
`ifndef FETCH_SKID_EN
         // Response lost to back-pressure: point the PC back at it so it is re-fetched.
         if (req_vld_q && stall) begin
            pc_q <= req_pc_q;
         end
`endif
         unique case (out_sel)
            LD_SKID: begin
               out_valid_q <= 1'b1;
               out_inst_q  <= skid_inst;
               out_pc_q    <= skid_pc;
            end
            LD_MEM: begin
               out_valid_q <= 1'b1;
               out_inst_q  <= bus.imem_rdata;
               out_pc_q    <= req_pc_q;
            end
            LD_CLEAR: out_valid_q <= 1'b0;
            LD_HOLD:  out_valid_q <= out_valid_q;
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_inst  = out_inst_q;
   assign bus.out_pc    = out_pc_q;

endmodule
